tpu_launcher: RTL and testbench

TPU_LAUNCHER -- requirements
Module: tpu_launcher

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/tpu_launcher.sv | 119 +++++++++++
 tb/tb_tpu_launcher.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU launcher: controller states, counter width and
// the result-word count derived from the command dimensions.
package tpu_pkg;

    localparam int CNT_W      = 16;
    localparam int LANES      = 4;
    localparam int LANE_SHIFT = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_OUT,
        ST_FIN
    } state_t;

    // One C word packs LANES rows of m, so each column needs ceil(m/LANES) words.
    function automatic logic [CNT_W-1:0] calc_words(input logic [7:0] m, input logic [7:0] n);
        logic [CNT_W-1:0] groups;
        groups = (CNT_W'(m) + CNT_W'(LANES - 1)) >> LANE_SHIFT;
        return groups * CNT_W'(n);
    endfunction

endpackage

// File: rtl/tpu_launcher.sv
// Host-command front end for the TPU: launches a job, waits out the busy
// handshake with a timeout, then streams the C buffer back as result beats.
module tpu_launcher
    import tpu_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF,
    parameter int               C_W     = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_k,
    input  logic [7:0]       cmd_m,
    input  logic [7:0]       cmd_n,
    output logic             in_valid,
    output logic [7:0]       K,
    output logic [7:0]       M,
    output logic [7:0]       N,
    input  logic             busy,
    output logic [15:0]      C_index,
    input  logic [C_W-1:0]   C_data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [C_W-1:0]   res_data,
    output logic             res_last,
    output logic             done,
    output logic             err_timeout
);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_k;
    logic [7:0]       r_m;
    logic [7:0]       r_n;
    logic [CNT_W-1:0] r_words;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_beat;
    logic [C_W-1:0]   r_res_data;
    logic             w_last;
    logic             w_timeout;
    logic             w_err;

    assign w_last    = (r_beat == r_words - CNT_W'(1));
    assign w_timeout = (r_cnt == TIMEOUT);

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE:    if (cmd_valid) w_next = ST_LAUNCH;
            // A zero dimension still passes through LAUNCH, but never raises in_valid.
            ST_LAUNCH:  w_next = r_zero ? ST_FIN : ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (busy) begin
                    w_next = ST_WAIT_LO;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!busy) begin
                    w_next = ST_RD_ADDR;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_RD_ADDR: w_next = ST_RD_DATA;
            ST_RD_DATA: w_next = ST_OUT;
            ST_OUT:     if (res_ready) w_next = w_last ? ST_FIN : ST_RD_ADDR;
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_words    <= '0;
            r_zero     <= 1'b0;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next;
            // Restarts on every state change, so each wait state gets its own budget.
            r_cnt   <= (w_next == r_state) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == ST_IDLE && cmd_valid) begin
                r_k     <= cmd_k;
                r_m     <= cmd_m;
                r_n     <= cmd_n;
                r_words <= calc_words(cmd_m, cmd_n);
                r_zero  <= (cmd_k == 8'd0) || (cmd_m == 8'd0) || (cmd_n == 8'd0);
                r_beat  <= '0;
            end
            if (r_state == ST_RD_DATA) r_res_data <= C_data_out;
            if (r_state == ST_OUT && res_ready) r_beat <= r_beat + CNT_W'(1);
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign in_valid    = (r_state == ST_LAUNCH) && !r_zero;
    assign K           = r_k;
    assign M           = r_m;
    assign N           = r_n;
    assign C_index     = (r_state == ST_RD_ADDR || r_state == ST_RD_DATA) ? r_beat : 16'd0;
    assign res_valid   = (r_state == ST_OUT);
    assign res_data    = r_res_data;
    assign res_last    = (r_state == ST_OUT) && w_last;
    assign done        = (r_state == ST_FIN);
    assign err_timeout = w_err;

endmodule

// File: tb/tb_tpu_launcher.sv
// Bench for tpu_launcher: a table of commands, randomized commands against a
// word-count/stream model, plus timeout, reset-abort and held-valid sequences.
module tb_tpu_launcher;

    localparam int CW = 128;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_k, cmd_m, cmd_n;
    logic          in_valid;
    logic [7:0]    K, M, N;
    logic          busy;
    logic [15:0]   C_index;
    logic [CW-1:0] C_data_out;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_data;
    logic          res_last;
    logic          done;
    logic          err_timeout;

    logic          t_cmd_ready, t_in_valid, t_res_valid, t_res_last, t_done, t_err_timeout;
    logic [7:0]    t_K, t_M, t_N;
    logic [15:0]   t_C_index;
    logic [CW-1:0] t_res_data;

    logic [15:0]   cidx_q;

    int vectors;
    int miscompares;

    tpu_launcher #(.C_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k(cmd_k), .cmd_m(cmd_m), .cmd_n(cmd_n), .in_valid(in_valid),
        .K(K), .M(M), .N(N), .busy(busy), .C_index(C_index), .C_data_out(C_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .done(done), .err_timeout(err_timeout)
    );

    tpu_launcher #(.C_W(CW), .TIMEOUT(16'd16)) dut_t (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_k(cmd_k), .cmd_m(cmd_m), .cmd_n(cmd_n), .in_valid(t_in_valid),
        .K(t_K), .M(t_M), .N(t_N), .busy(busy), .C_index(t_C_index), .C_data_out(C_data_out),
        .res_valid(t_res_valid), .res_ready(res_ready), .res_data(t_res_data),
        .res_last(t_res_last), .done(t_done), .err_timeout(t_err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C buffer model: one-cycle read latency, distinct contents per address.
    function automatic logic [CW-1:0] cmem(input logic [15:0] idx);
        logic [31:0] a;
        a = {idx ^ 16'hC0DE, idx * 16'd37 + 16'h1234};
        return {a, ~a, a ^ 32'h0F0F_0F0F, idx, ~idx};
    endfunction

    always @(posedge clk) cidx_q <= C_index;
    assign C_data_out = cmem(cidx_q);

    function automatic int ref_words(input int k, input int m, input int n);
        int cols_words;
        if (k == 0 || m == 0 || n == 0) return 0;
        cols_words = m / 4;
        if (m % 4 != 0) cols_words = cols_words + 1;
        return cols_words * n;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, CW'(cmd_ready), CW'(0));
        chk({tag, "_in_valid"},  CW'(in_valid),  CW'(0));
        chk({tag, "_K"},         CW'(K),         CW'(0));
        chk({tag, "_M"},         CW'(M),         CW'(0));
        chk({tag, "_N"},         CW'(N),         CW'(0));
        chk({tag, "_C_index"},   CW'(C_index),   CW'(0));
        chk({tag, "_res_valid"}, CW'(res_valid), CW'(0));
        chk({tag, "_res_data"},  res_data,       CW'(0));
        chk({tag, "_res_last"},  CW'(res_last),  CW'(0));
        chk({tag, "_done"},      CW'(done),      CW'(0));
        chk({tag, "_err"},       CW'(err_timeout), CW'(0));
    endtask

    task automatic do_reset(input string tag);
        step();
        cmd_valid = 1'b0; busy = 1'b0; res_ready = 1'b0; rst = 1'b1;
        step();
        #1;
        check_reset_outputs(tag);
        step();
        rst = 1'b0;
        #1;
        chk({tag, "_ready_after"}, CW'(cmd_ready), CW'(1));
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] k, input logic [7:0] m,
                           input logic [7:0] n, input int exp_words, input int bdel,
                           input int blen, input int rmode, input bit noise, input bit hold,
                           input logic [7:0] nk, input logic [7:0] nm, input logic [7:0] nn,
                           input int abort_beat);
        int cyc, inv_cyc, inv_cnt, nbeats, last_cyc, done_cyc, rdy_seen;
        logic [CW-1:0] prev_data;
        bit prev_stall, fin, aborted;
        inv_cyc = -1; inv_cnt = 0; nbeats = 0; last_cyc = -1; done_cyc = -1; rdy_seen = 0;
        prev_data = '0; prev_stall = 1'b0; fin = 1'b0; aborted = 1'b0;
        step();
        cmd_k = k; cmd_m = m; cmd_n = n; cmd_valid = 1'b1; res_ready = 1'b0; busy = 1'b0;
        #1;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            step(); #1; cyc++;
        end
        chk({tag, "_accept"}, CW'(cmd_ready), CW'(1));
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        cyc = 0;
        while (!fin && cyc < 800) begin
            step();
            cyc++;
            if (hold) begin
                cmd_k = nk; cmd_m = nm; cmd_n = nn;
            end else begin
                cmd_valid = 1'b0;
            end
            if (inv_cyc >= 0 && cyc >= inv_cyc + bdel && cyc < inv_cyc + bdel + blen)
                busy = 1'b1;
            else if (noise && (inv_cyc < 0 || cyc > inv_cyc + bdel + blen))
                busy = 1'($urandom_range(0, 1));
            else
                busy = 1'b0;
            case (rmode)
                0:       res_ready = 1'b1;
                1:       res_ready = cyc[0];
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cmd_ready) rdy_seen++;
            if (in_valid) begin
                inv_cnt++;
                if (inv_cyc < 0) inv_cyc = cyc;
                chk({tag, "_K"}, CW'(K), CW'(k));
                chk({tag, "_M"}, CW'(M), CW'(m));
                chk({tag, "_N"}, CW'(N), CW'(n));
            end
            if (res_valid) begin
                chk({tag, "_cidx_in_out"}, CW'(C_index), CW'(0));
                if (prev_stall) chk({tag, "_stall_stable"}, res_data, prev_data);
                if (abort_beat == nbeats) begin
                    rst = 1'b1;
                    res_ready = 1'b0;
                    aborted = 1'b1;
                    fin = 1'b1;
                end else if (res_ready) begin
                    chk({tag, "_data"}, res_data, cmem(16'(nbeats)));
                    chk({tag, "_last"}, CW'(res_last), CW'(nbeats == exp_words - 1));
                    if (rmode == 0 && nbeats > 0)
                        chk({tag, "_gap"}, CW'(cyc - last_cyc), CW'(3));
                    last_cyc = cyc;
                    nbeats++;
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
        end
        if (aborted) begin
            step();
            #1;
            check_reset_outputs({tag, "_abort"});
            step();
            rst = 1'b0;
            #1;
            chk({tag, "_ready_post_abort"}, CW'(cmd_ready), CW'(1));
            chk({tag, "_no_done_abort"}, CW'(done), CW'(0));
            return;
        end
        chk({tag, "_done_seen"}, CW'(done_cyc >= 0), CW'(1));
        chk({tag, "_in_valid_cnt"}, CW'(inv_cnt), CW'(exp_words > 0 ? 1 : 0));
        chk({tag, "_beats"}, CW'(nbeats), CW'(exp_words));
        chk({tag, "_no_ready_busy"}, CW'(rdy_seen), CW'(0));
        if (exp_words == 0) begin
            chk({tag, "_done_lat"}, CW'(done_cyc), CW'(2));
        end else begin
            chk({tag, "_launch_lat"}, CW'(inv_cyc), CW'(1));
            chk({tag, "_done_after_last"}, CW'(done_cyc - last_cyc), CW'(1));
        end
        if (hold) chk({tag, "_K_held"}, CW'(K), CW'(k));
    endtask

    task automatic timeout_seq(input string tag, input bit wlo);
        int tinv, terr, nerr, ndone, rdy_next;
        tinv = -1; terr = -1; nerr = 0; ndone = 0; rdy_next = 0;
        step();
        cmd_k = 8'd1; cmd_m = 8'd1; cmd_n = 8'd1; cmd_valid = 1'b1; busy = 1'b0; res_ready = 1'b1;
        #1;
        chk({tag, "_accept"}, CW'(t_cmd_ready), CW'(1));
        for (int c = 1; c <= 40; c++) begin
            step();
            cmd_valid = 1'b0;
            busy = wlo && tinv >= 0 && c >= tinv + 3;
            #1;
            if (t_in_valid && tinv < 0) tinv = c;
            if (terr >= 0 && c == terr + 1) rdy_next = int'(t_cmd_ready);
            if (t_err_timeout) begin
                nerr++;
                if (terr < 0) terr = c;
            end
            if (t_done) ndone++;
        end
        chk({tag, "_launch"}, CW'(tinv), CW'(1));
        chk({tag, "_err_cycle"}, CW'(terr), CW'(tinv + (wlo ? 20 : 17)));
        chk({tag, "_err_count"}, CW'(nerr), CW'(1));
        chk({tag, "_no_done"}, CW'(ndone), CW'(0));
        chk({tag, "_ready_next"}, CW'(rdy_next), CW'(1));
        chk({tag, "_kmn_hold"}, CW'({t_K, t_M, t_N}), CW'(24'h010101));
        chk({tag, "_no_results"}, CW'({t_res_valid, t_res_last, t_C_index}), CW'(0));
        chk({tag, "_res_data_clear"}, t_res_data, CW'(0));
    endtask

    typedef struct {
        logic [7:0] k, m, n;
        int bdel, blen, rmode;
        int words;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_m = '0; cmd_n = '0;
        busy = 1'b0; res_ready = 1'b0;

        tbl[0] = '{k: 8'd4, m: 8'd4,   n: 8'd4, bdel: 2, blen: 20, rmode: 0, words: 4};
        tbl[1] = '{k: 8'd3, m: 8'd5,   n: 8'd3, bdel: 1, blen: 5,  rmode: 1, words: 6};
        tbl[2] = '{k: 8'd4, m: 8'd4,   n: 8'd0, bdel: 1, blen: 1,  rmode: 0, words: 0};
        tbl[3] = '{k: 8'd0, m: 8'd7,   n: 8'd7, bdel: 1, blen: 1,  rmode: 0, words: 0};
        tbl[4] = '{k: 8'd5, m: 8'd0,   n: 8'd2, bdel: 1, blen: 1,  rmode: 0, words: 0};
        tbl[5] = '{k: 8'd1, m: 8'd1,   n: 8'd1, bdel: 3, blen: 2,  rmode: 2, words: 1};
        tbl[6] = '{k: 8'd9, m: 8'd9,   n: 8'd2, bdel: 1, blen: 3,  rmode: 0, words: 6};
        tbl[7] = '{k: 8'd2, m: 8'd255, n: 8'd1, bdel: 2, blen: 4,  rmode: 0, words: 64};
        tbl[8] = '{k: 8'd7, m: 8'd13,  n: 8'd2, bdel: 4, blen: 8,  rmode: 1, words: 8};

        do_reset("init");

        for (int i = 0; i < 9; i++) begin
            run_cmd($sformatf("tbl%0d", i), tbl[i].k, tbl[i].m, tbl[i].n, tbl[i].words,
                    tbl[i].bdel, tbl[i].blen, tbl[i].rmode, 1'b0, 1'b0,
                    8'd0, 8'd0, 8'd0, -1);
        end

        for (int i = 0; i < 12; i++) begin
            logic [7:0] rk, rm, rn;
            rk = 8'($urandom_range(0, 6));
            rm = 8'($urandom_range(0, 20));
            rn = 8'($urandom_range(0, 5));
            run_cmd($sformatf("rnd%0d", i), rk, rm, rn, ref_words(rk, rm, rn),
                    $urandom_range(1, 4), $urandom_range(1, 10), $urandom_range(0, 2),
                    1'b1, 1'b0, 8'd0, 8'd0, 8'd0, -1);
        end

        // Reset while beat 2 is being offered, then a normal command.
        run_cmd("abort", 8'd2, 8'd8, 8'd2, 4, 2, 3, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2);
        run_cmd("post_abort", 8'd3, 8'd4, 8'd2, 2, 1, 4, 0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, -1);

        // cmd_valid held across two back-to-back runs; inputs change mid-run.
        run_cmd("hold1", 8'd4, 8'd4, 8'd1, 1, 2, 3, 0, 1'b0, 1'b1, 8'd6, 8'd3, 8'd2, -1);
        run_cmd("hold2", 8'd6, 8'd3, 8'd2, 2, 1, 2, 0, 1'b0, 1'b1, 8'd6, 8'd3, 8'd2, -1);

        do_reset("pre_to");
        timeout_seq("to_hi", 1'b0);
        do_reset("pre_to_lo");
        timeout_seq("to_lo", 1'b1);
        do_reset("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
